dcache_miss_handler: RTL and testbench
======================================

DCACHE_MISS_HANDLER -- requirements
Module: dcache_miss_handler

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 128, giving the cache line width in bits.
REQ-002 SHALL have parameter BEAT_WIDTH, default 32, giving the memory beat width in bits; LINE_WIDTH is a power-of-two multiple of BEAT_WIDTH; NBEATS = LINE_WIDTH/BEAT_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, giving the physical address width.
REQ-004 SHALL have parameter WRITE_ALLOCATE, default 1; 1 = store miss refills the line, 0 = store miss writes through one beat.
REQ-005 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 miss_valid_i / miss_ready_o  in/out  1  miss request handshake; accepted when both are high.
REQ-008 miss_addr_i  in  ADDR_WIDTH  missing address.
REQ-009 miss_is_store_i  in  1  request is a store (1) or a load (0).
REQ-010 miss_wdata_i / miss_be_i  in  BEAT_WIDTH / BEAT_WIDTH/8  store data and byte enables, beat-aligned.
REQ-011 victim_dirty_i, victim_addr_i, victim_line_i  in  1 / ADDR_WIDTH / LINE_WIDTH  eviction candidate, sampled at accept.
REQ-012 done_valid_o  out  1  one-cycle pulse when the miss completes.
REQ-013 done_line_o  out  LINE_WIDTH  refilled line.
REQ-014 done_alloc_o  out  1  high when done_line_o shall be written into the data store.
REQ-015 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/1/ADDR_WIDTH/BEAT_WIDTH/BEAT_WIDTH/8  beat request.
REQ-016 mem_gnt_i, mem_rvalid_i, mem_rdata_i  in  1/1/BEAT_WIDTH  grant, read return, read data.

Function
REQ-017 SHALL be an FSM with states IDLE, WB_BEAT, RD_REQ, RD_WAIT, WT_BEAT, DONE.
REQ-018 miss_ready_o SHALL be high only in IDLE; all request and victim inputs are registered at accept.
REQ-019 On accept: victim dirty and (load or WRITE_ALLOCATE=1) -> WB_BEAT; load, or store with WRITE_ALLOCATE=1 -> RD_REQ; store with WRITE_ALLOCATE=0 -> WT_BEAT (victim ignored).
REQ-020 WB_BEAT: mem_req_o=1, mem_we_o=1, mem_be_o all ones, mem_addr_o = line-aligned victim address + beat*BEAT_WIDTH/8, mem_wdata_o = victim beat; each mem_gnt_i increments the beat counter; after beat NBEATS-1 -> RD_REQ.
REQ-021 RD_REQ: mem_req_o=1, mem_we_o=0, address = line-aligned miss address + beat offset; on mem_gnt_i -> RD_WAIT; at most one read outstanding.
REQ-022 RD_WAIT: on mem_rvalid_i, the beat is stored at line bits [beat*BEAT_WIDTH +: BEAT_WIDTH]; last beat -> DONE, otherwise RD_REQ with beat+1.
REQ-023 For an allocating store, the store beat SHALL be merged into the refilled line under miss_be_i at the word offset of miss_addr_i.
REQ-024 WT_BEAT: single write of miss_wdata_i/miss_be_i to the beat-aligned miss address; on mem_gnt_i -> DONE with done_alloc_o=0.
REQ-025 DONE: done_valid_o=1 for exactly one cycle, then IDLE; done_alloc_o=1 for every path except WT_BEAT.
REQ-026 mem_req_o and its address/data SHALL stay stable until mem_gnt_i; mem_rvalid_i outside RD_WAIT is ignored.
REQ-027 The beat counter SHALL be $clog2(NBEATS) bits, clear on entering WB_BEAT or RD_REQ from IDLE/WB_BEAT, and wrap to 0 after NBEATS-1; NBEATS=1 uses a one-bit counter held at 0.
REQ-028 mem_gnt_i and mem_rvalid_i in the same cycle in RD_REQ: the grant SHALL be taken and the rvalid ignored.

Reset
REQ-029 Asserting rst_ni low at any time SHALL force IDLE, beat=0, line buffer=0, and all outputs to 0 except miss_ready_o=1; an in-flight miss is abandoned with no done pulse.

Structure
REQ-030 The state enum, MEM size encodings and the beat-offset/byte-enable merge functions SHALL live in dcache_pkg.
REQ-031 Single module; no sub-module.

Verification
REQ-032 Clean load miss, LINE 128/BEAT 32, addr 0x1004: four reads at 0x1000..0x100C, then one done pulse with line = returned beats in order and done_alloc_o=1.
REQ-033 Dirty victim 0x2000 plus load miss 0x3000: four writes to 0x2000..0x200C precede any read; grants delayed three cycles each keep request/data stable.
REQ-034 Store miss with WRITE_ALLOCATE=1, addr 0x1008, be=4'b0011, data 0xAAAA5555: refilled beat 2 has its low halfword replaced by 0x5555.
REQ-035 Store miss with WRITE_ALLOCATE=0, dirty victim: exactly one write to 0x1008 with be 0011 and no victim writeback; done_alloc_o=0.
REQ-036 rst_ni low during RD_WAIT beat 1: outputs zero next edge, miss_ready_o=1, no done pulse; a fresh miss then completes normally.

Source files
------------

// File: rtl/dcache_pkg.sv
// Purpose : shared types and helpers for the data-cache miss handler.
// Contents: miss FSM state enum, memory access-size encodings, beat address
//           generation and byte-enable merge helpers (width-generic, callers
//           cast to their own widths).
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_BEAT = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WT_BEAT = 3'd4,
        DONE    = 3'd5
    } miss_state_e;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE  = 2'd0,
        MEM_SIZE_HALF  = 2'd1,
        MEM_SIZE_WORD  = 2'd2,
        MEM_SIZE_DWORD = 2'd3
    } mem_size_e;

    // Upper bounds for the width-generic helpers.
    localparam int unsigned FN_ADDR_W = 64;
    localparam int unsigned FN_DATA_W = 1024;
    localparam int unsigned FN_BE_W   = FN_DATA_W / 8;

    // Line-aligned base of addr plus the byte offset of the given beat.
    function automatic logic [FN_ADDR_W-1:0] beat_addr(
        input logic [FN_ADDR_W-1:0] addr,
        input int unsigned          line_bytes,
        input int unsigned          beat_bytes,
        input int unsigned          beat
    );
        logic [FN_ADDR_W-1:0] base;
        base = addr & ~(FN_ADDR_W'(line_bytes) - FN_ADDR_W'(1));
        return base + FN_ADDR_W'(beat) * FN_ADDR_W'(beat_bytes);
    endfunction

    // Replace the bytes of old_data selected by be with bytes of new_data.
    function automatic logic [FN_DATA_W-1:0] be_merge(
        input logic [FN_DATA_W-1:0] old_data,
        input logic [FN_DATA_W-1:0] new_data,
        input logic [FN_BE_W-1:0]   be
    );
        logic [FN_DATA_W-1:0] res;
        res = old_data;
        for (int b = 0; b < int'(FN_BE_W); b++) begin
            if (be[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_miss_handler_if.sv
// Purpose : bundle of the miss-request, completion and memory-beat buses of
//           the data-cache miss handler.
// Modports: slave  - the miss handler (consumes requests, drives memory bus)
//           master - the environment (cache pipeline plus memory)
interface dcache_miss_handler_if #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned BEAT_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    localparam int unsigned BE_W = BEAT_WIDTH / 8;

    // miss request
    logic                  miss_valid_i;
    logic                  miss_ready_o;
    logic [ADDR_WIDTH-1:0] miss_addr_i;
    logic                  miss_is_store_i;
    logic [BEAT_WIDTH-1:0] miss_wdata_i;
    logic [BE_W-1:0]       miss_be_i;
    logic                  victim_dirty_i;
    logic [ADDR_WIDTH-1:0] victim_addr_i;
    logic [LINE_WIDTH-1:0] victim_line_i;
    // completion
    logic                  done_valid_o;
    logic [LINE_WIDTH-1:0] done_line_o;
    logic                  done_alloc_o;
    // memory beat bus
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [BEAT_WIDTH-1:0] mem_wdata_o;
    logic [BE_W-1:0]       mem_be_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [BEAT_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  miss_valid_i, miss_addr_i, miss_is_store_i, miss_wdata_i, miss_be_i,
               victim_dirty_i, victim_addr_i, victim_line_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output miss_ready_o, done_valid_o, done_line_o, done_alloc_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output miss_valid_i, miss_addr_i, miss_is_store_i, miss_wdata_i, miss_be_i,
               victim_dirty_i, victim_addr_i, victim_line_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  miss_ready_o, done_valid_o, done_line_o, done_alloc_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/dcache_miss_handler.sv
// Purpose : data-cache miss handler. Accepts one miss at a time, writes back a
//           dirty victim line beat by beat, refills the missing line with one
//           read outstanding at a time (merging store data for allocating
//           stores), or writes a single beat through for non-allocating stores.
// Ports   : clk_i    - clock, rising edge
//           rst_ni   - asynchronous active-low reset
//           miss_bus - dcache_miss_handler_if.slave: miss request, victim,
//                      completion and memory beat signals
// All outputs are registers loaded from the next-state values.
module dcache_miss_handler
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned BEAT_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WRITE_ALLOCATE = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    dcache_miss_handler_if.slave miss_bus
);

    localparam int unsigned NBEATS     = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned BEAT_BYTES = BEAT_WIDTH / 8;
    localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
    localparam int unsigned BE_W       = BEAT_BYTES;
    localparam int unsigned CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned OFF_LSB    = $clog2(BEAT_BYTES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic             WA_EN     = (WRITE_ALLOCATE != 0);

    miss_state_e           state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  store_q, store_d;
    logic [BEAT_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
    logic [LINE_WIDTH-1:0] vline_q, vline_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;

    logic                  ready_q, ready_d;
    logic                  done_valid_q, done_valid_d;
    logic                  done_alloc_q, done_alloc_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [BEAT_WIDTH-1:0] mwdata_q, mwdata_d;
    logic [BE_W-1:0]       mbe_q, mbe_d;

    logic [CNT_W-1:0]      word_idx;
    logic [BEAT_WIDTH-1:0] rd_beat;

    // Beat of the line that an allocating store lands in.
    assign word_idx = (NBEATS > 1) ? addr_q[OFF_LSB +: CNT_W] : '0;

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        store_d = store_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        vaddr_d = vaddr_q;
        vline_d = vline_q;
        line_d  = line_q;
        rd_beat = miss_bus.mem_rdata_i;

        case (state_q)
            IDLE: begin
                if (miss_bus.miss_valid_i) begin
                    addr_d  = miss_bus.miss_addr_i;
                    store_d = miss_bus.miss_is_store_i;
                    wdata_d = miss_bus.miss_wdata_i;
                    be_d    = miss_bus.miss_be_i;
                    vaddr_d = miss_bus.victim_addr_i;
                    vline_d = miss_bus.victim_line_i;
                    line_d  = '0;
                    beat_d  = '0;
                    if (miss_bus.miss_is_store_i && !WA_EN) begin
                        state_d = WT_BEAT;
                    end else if (miss_bus.victim_dirty_i) begin
                        state_d = WB_BEAT;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            WB_BEAT: begin
                if (miss_bus.mem_gnt_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = RD_REQ;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            // rvalid is not looked at here, so a coincident grant wins.
            RD_REQ: begin
                if (miss_bus.mem_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (miss_bus.mem_rvalid_i) begin
                    if (store_q && WA_EN && (beat_q == word_idx)) begin
                        rd_beat = BEAT_WIDTH'(be_merge(FN_DATA_W'(miss_bus.mem_rdata_i),
                                                       FN_DATA_W'(wdata_q),
                                                       FN_BE_W'(be_q)));
                    end
                    line_d[32'(beat_q)*BEAT_WIDTH +: BEAT_WIDTH] = rd_beat;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            WT_BEAT: begin
                if (miss_bus.mem_gnt_i) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid in that state.
        ready_d      = (state_d == IDLE);
        done_valid_d = (state_d == DONE);
        done_alloc_d = (state_d == DONE) && !(store_d && !WA_EN);
        req_d        = (state_d inside {WB_BEAT, RD_REQ, WT_BEAT});
        we_d         = (state_d inside {WB_BEAT, WT_BEAT});
        maddr_d      = '0;
        mwdata_d     = '0;
        mbe_d        = '0;
        case (state_d)
            WB_BEAT: begin
                maddr_d  = ADDR_WIDTH'(beat_addr(FN_ADDR_W'(vaddr_d), LINE_BYTES,
                                                 BEAT_BYTES, 32'(beat_d)));
                mwdata_d = vline_d[32'(beat_d)*BEAT_WIDTH +: BEAT_WIDTH];
                mbe_d    = '1;
            end
            RD_REQ: begin
                maddr_d = ADDR_WIDTH'(beat_addr(FN_ADDR_W'(addr_d), LINE_BYTES,
                                                BEAT_BYTES, 32'(beat_d)));
            end
            WT_BEAT: begin
                maddr_d  = addr_d & ~ADDR_WIDTH'(BEAT_BYTES - 1);
                mwdata_d = wdata_d;
                mbe_d    = be_d;
            end
            default: ;
        endcase
    end

    // State, captured request and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            addr_q       <= '0;
            store_q      <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            vaddr_q      <= '0;
            vline_q      <= '0;
            line_q       <= '0;
            ready_q      <= 1'b1;
            done_valid_q <= 1'b0;
            done_alloc_q <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            maddr_q      <= '0;
            mwdata_q     <= '0;
            mbe_q        <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            store_q      <= store_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            vaddr_q      <= vaddr_d;
            vline_q      <= vline_d;
            line_q       <= line_d;
            ready_q      <= ready_d;
            done_valid_q <= done_valid_d;
            done_alloc_q <= done_alloc_d;
            req_q        <= req_d;
            we_q         <= we_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            mbe_q        <= mbe_d;
        end
    end

    assign miss_bus.miss_ready_o = ready_q;
    assign miss_bus.done_valid_o = done_valid_q;
    assign miss_bus.done_line_o  = line_q;
    assign miss_bus.done_alloc_o = done_alloc_q;
    assign miss_bus.mem_req_o    = req_q;
    assign miss_bus.mem_we_o     = we_q;
    assign miss_bus.mem_addr_o   = maddr_q;
    assign miss_bus.mem_wdata_o  = mwdata_q;
    assign miss_bus.mem_be_o     = mbe_q;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Bench for dcache_miss_handler: instance 0 allocates on store misses,
// instance 1 writes stores through. A model predicts each miss's memory
// transactions and completion; a monitor compares them as the DUTs emit them.
module tb_dcache_miss_handler;
    localparam int unsigned LW = 128;
    localparam int unsigned BW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NB = LW / BW;
    localparam int unsigned BB = BW / 8;

    typedef logic [BW-1:0] beat_t;
    typedef logic [LW-1:0] line_t;
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        beat_t         wdata;
        logic [BB-1:0] be;
    } mem_txn_t;
    typedef struct {
        line_t line;
        logic  alloc;
        logic  chk_line;
    } done_t;

    logic clk;
    logic rst_n;

    logic          drv_valid [2];
    logic [AW-1:0] drv_addr  [2];
    logic          drv_store [2];
    beat_t         drv_wdata [2];
    logic [BB-1:0] drv_be    [2];
    logic          drv_vdirty[2];
    logic [AW-1:0] drv_vaddr [2];
    line_t         drv_vline [2];
    logic          m_gnt     [2];
    logic          m_rvalid  [2];
    beat_t         m_rdata   [2];

    logic          o_ready [2];
    logic          o_done  [2];
    line_t         o_line  [2];
    logic          o_alloc [2];
    logic          o_req   [2];
    logic          o_we    [2];
    logic [AW-1:0] o_addr  [2];
    beat_t         o_wdata [2];
    logic [BB-1:0] o_be    [2];

    mem_txn_t exp_mem  [2][$];
    done_t    exp_done [2][$];
    beat_t    env_mem [logic [AW:0]];
    beat_t    ref_mem [logic [AW:0]];

    int checks = 0;
    int errors = 0;
    int gnt_dly_min = 0, gnt_dly_max = 2, rv_dly_min = 0, rv_dly_max = 2;
    bit spur_en = 1'b1;
    int rd_gnts [2] = '{0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_env
        dcache_miss_handler_if #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

        dcache_miss_handler #(
            .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW),
            .WRITE_ALLOCATE((g == 0) ? 1 : 0)
        ) dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .miss_bus(bus)
        );

        assign bus.miss_valid_i    = drv_valid[g];
        assign bus.miss_addr_i     = drv_addr[g];
        assign bus.miss_is_store_i = drv_store[g];
        assign bus.miss_wdata_i    = drv_wdata[g];
        assign bus.miss_be_i       = drv_be[g];
        assign bus.victim_dirty_i  = drv_vdirty[g];
        assign bus.victim_addr_i   = drv_vaddr[g];
        assign bus.victim_line_i   = drv_vline[g];
        assign bus.mem_gnt_i       = m_gnt[g];
        assign bus.mem_rvalid_i    = m_rvalid[g];
        assign bus.mem_rdata_i     = m_rdata[g];

        assign o_ready[g] = bus.miss_ready_o;
        assign o_done[g]  = bus.done_valid_o;
        assign o_line[g]  = bus.done_line_o;
        assign o_alloc[g] = bus.done_alloc_o;
        assign o_req[g]   = bus.mem_req_o;
        assign o_we[g]    = bus.mem_we_o;
        assign o_addr[g]  = bus.mem_addr_o;
        assign o_wdata[g] = bus.mem_wdata_o;
        assign o_be[g]    = bus.mem_be_o;
    end

    // Power-on memory contents, a fixed function of the beat address.
    function automatic beat_t init_word(input logic [AW:0] key);
        beat_t k;
        k = key[AW-1:0];
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {31'b0, key[AW]};
    endfunction

    function automatic beat_t env_rd(input int g, input logic [AW-1:0] a);
        logic [AW:0] key;
        key = {g[0], a};
        return env_mem.exists(key) ? env_mem[key] : init_word(key);
    endfunction

    function automatic beat_t ref_rd(input int g, input logic [AW-1:0] a);
        logic [AW:0] key;
        key = {g[0], a};
        return ref_mem.exists(key) ? ref_mem[key] : init_word(key);
    endfunction

    function automatic beat_t merge_bytes(input beat_t old_w, input beat_t new_w, input logic [BB-1:0] be);
        beat_t r;
        r = old_w;
        for (int b = 0; b < int'(BB); b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen or timed out, required otherwise", name);
    endtask

    // Expected behaviour of one miss: memory traffic in order, then completion.
    task automatic model_miss(input int g, input logic [AW-1:0] addr, input logic store,
                              input beat_t wdata, input logic [BB-1:0] be, input logic dirty,
                              input logic [AW-1:0] vaddr, input line_t vline);
        mem_txn_t      t;
        done_t         d;
        logic [AW-1:0] base, a;
        line_t         line;
        beat_t         w;
        int            widx;
        if (store && g == 1) begin
            a = {addr[AW-1:2], 2'b00};
            t = '{we: 1'b1, addr: a, wdata: wdata, be: be};
            exp_mem[g].push_back(t);
            ref_mem[{g[0], a}] = merge_bytes(ref_rd(g, a), wdata, be);
            d = '{line: '0, alloc: 1'b0, chk_line: 1'b0};
            exp_done[g].push_back(d);
        end else begin
            if (dirty) begin
                base = {vaddr[AW-1:4], 4'b0000};
                for (int i = 0; i < int'(NB); i++) begin
                    a = base + AW'(i * BB);
                    t = '{we: 1'b1, addr: a, wdata: vline[i*BW +: BW], be: '1};
                    exp_mem[g].push_back(t);
                    ref_mem[{g[0], a}] = vline[i*BW +: BW];
                end
            end
            base = {addr[AW-1:4], 4'b0000};
            widx = int'(addr[3:2]);
            line = '0;
            for (int i = 0; i < int'(NB); i++) begin
                a = base + AW'(i * BB);
                t = '{we: 1'b0, addr: a, wdata: '0, be: '0};
                exp_mem[g].push_back(t);
                w = ref_rd(g, a);
                if (store && i == widx) w = merge_bytes(w, wdata, be);
                line[i*BW +: BW] = w;
            end
            d = '{line: line, alloc: 1'b1, chk_line: 1'b1};
            exp_done[g].push_back(d);
        end
    endtask

    // Present one miss once the handler is ready; called at posedge+1.
    task automatic issue(input int g, input logic [AW-1:0] addr, input logic store,
                         input beat_t wdata, input logic [BB-1:0] be, input logic dirty,
                         input logic [AW-1:0] vaddr, input line_t vline);
        int n = 0;
        while (!o_ready[g] && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready[g]) begin
            fail_event("ready_timeout");
            return;
        end
        drv_valid[g] = 1'b1;  drv_addr[g] = addr;   drv_store[g] = store;
        drv_wdata[g] = wdata; drv_be[g] = be;       drv_vdirty[g] = dirty;
        drv_vaddr[g] = vaddr; drv_vline[g] = vline;
        model_miss(g, addr, store, wdata, be, dirty, vaddr, vline);
        @(posedge clk); #1;
        drv_valid[g]  = 1'b0;
        drv_addr[g]   = $urandom;
        drv_store[g]  = 1'($urandom);
        drv_wdata[g]  = $urandom;
        drv_be[g]     = BB'($urandom);
        drv_vdirty[g] = 1'($urandom);
        drv_vaddr[g]  = $urandom;
        drv_vline[g]  = {$urandom, $urandom, $urandom, $urandom};
        check("ready_after_accept", line_t'(o_ready[g]), line_t'(1'b0));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_mem[0].size() + exp_mem[1].size() + exp_done[0].size() + exp_done[1].size()) != 0
               && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) fail_event("drain_timeout");
    endtask

    task automatic check_reset_outputs(input int g);
        check($sformatf("rst_ready%0d", g), line_t'(o_ready[g]), line_t'(1'b1));
        check($sformatf("rst_done%0d", g),  line_t'(o_done[g]),  '0);
        check($sformatf("rst_alloc%0d", g), line_t'(o_alloc[g]), '0);
        check($sformatf("rst_line%0d", g),  o_line[g],           '0);
        check($sformatf("rst_mem%0d", g),
              line_t'({o_req[g], o_we[g], o_addr[g], o_wdata[g], o_be[g]}), '0);
    endtask

    // Memory model: randomly delayed grants, one read return per read grant,
    // stray rvalids whenever no read is owed.
    bit            in_req  [2] = '{0, 0};
    int            gnt_cnt [2] = '{0, 0};
    bit            rd_pend [2] = '{0, 0};
    int            rd_cnt  [2] = '{0, 0};
    logic [AW-1:0] rd_addr [2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            m_gnt[g] = 1'b0; m_rvalid[g] = 1'b0; m_rdata[g] = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                m_gnt[g]    = 1'b0;
                m_rvalid[g] = 1'b0;
                m_rdata[g]  = $urandom;
                if (!rst_n) begin
                    in_req[g]  = 1'b0;
                    rd_pend[g] = 1'b0;
                    continue;
                end
                if (rd_pend[g]) begin
                    if (rd_cnt[g] == 0) begin
                        m_rvalid[g] = 1'b1;
                        m_rdata[g]  = env_rd(g, rd_addr[g]);
                        rd_pend[g]  = 1'b0;
                    end else begin
                        rd_cnt[g]--;
                    end
                end else if (spur_en && $urandom_range(3, 0) == 0) begin
                    m_rvalid[g] = 1'b1;
                end
                if (o_req[g]) begin
                    if (!in_req[g]) begin
                        in_req[g]  = 1'b1;
                        gnt_cnt[g] = $urandom_range(gnt_dly_max, gnt_dly_min);
                    end
                    if (gnt_cnt[g] == 0) begin
                        m_gnt[g]  = 1'b1;
                        in_req[g] = 1'b0;
                        if (o_we[g]) begin
                            env_mem[{g[0], o_addr[g]}] = merge_bytes(env_rd(g, o_addr[g]), o_wdata[g], o_be[g]);
                        end else begin
                            rd_pend[g] = 1'b1;
                            rd_addr[g] = o_addr[g];
                            rd_cnt[g]  = $urandom_range(rv_dly_max, rv_dly_min);
                            rd_gnts[g]++;
                        end
                    end else begin
                        gnt_cnt[g]--;
                    end
                end
            end
        end
    end

    // Monitor: request hold while ungranted, granted beats and completions.
    bit            p_req   [2] = '{0, 0};
    bit            p_gnt   [2] = '{0, 0};
    logic [69:0]   p_bus   [2];

    initial begin
        mem_txn_t t;
        done_t    d;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst_n) begin
                    p_req[g] = 1'b0;
                    continue;
                end
                if (p_req[g] && !p_gnt[g]) begin
                    check($sformatf("hold%0d", g),
                          line_t'({o_req[g], o_we[g], o_addr[g], o_wdata[g], o_be[g]}),
                          line_t'(p_bus[g]));
                end
                if (o_req[g] && m_gnt[g]) begin
                    if (exp_mem[g].size() == 0) begin
                        fail_event($sformatf("unexpected_mem%0d", g));
                    end else begin
                        t = exp_mem[g].pop_front();
                        check($sformatf("mem_we%0d", g),   line_t'(o_we[g]),   line_t'(t.we));
                        check($sformatf("mem_addr%0d", g), line_t'(o_addr[g]), line_t'(t.addr));
                        if (t.we) begin
                            check($sformatf("mem_wdata%0d", g), line_t'(o_wdata[g]), line_t'(t.wdata));
                            check($sformatf("mem_be%0d", g),    line_t'(o_be[g]),    line_t'(t.be));
                        end
                    end
                end
                if (o_done[g]) begin
                    if (exp_done[g].size() == 0 || exp_mem[g].size() != 0) begin
                        fail_event($sformatf("unexpected_done%0d", g));
                        if (exp_done[g].size() != 0) void'(exp_done[g].pop_front());
                    end else begin
                        d = exp_done[g].pop_front();
                        check($sformatf("done_alloc%0d", g), line_t'(o_alloc[g]), line_t'(d.alloc));
                        if (d.chk_line) check($sformatf("done_line%0d", g), o_line[g], d.line);
                    end
                end
                p_req[g] = o_req[g];
                p_gnt[g] = m_gnt[g];
                p_bus[g] = {o_req[g], o_we[g], o_addr[g], o_wdata[g], o_be[g]};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_gnts;
        int n;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            drv_valid[g] = 1'b0; drv_addr[g] = '0;  drv_store[g] = 1'b0; drv_wdata[g] = '0;
            drv_be[g] = '0;      drv_vdirty[g] = 1'b0; drv_vaddr[g] = '0; drv_vline[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean load miss.
        issue(0, 32'h0000_1004, 1'b0, '0, '0, 1'b0, '0, '0);
        wait_idle();

        // Dirty victim with slow grants.
        gnt_dly_min = 3; gnt_dly_max = 3;
        issue(0, 32'h0000_3000, 1'b0, '0, '0, 1'b1, 32'h0000_2000,
              {$urandom, $urandom, $urandom, $urandom});
        wait_idle();
        gnt_dly_min = 0; gnt_dly_max = 2;

        // Allocating store, low halfword of beat 2.
        issue(0, 32'h0000_1008, 1'b1, 32'hAAAA_5555, 4'b0011, 1'b0, '0, '0);
        wait_idle();

        // Write-through store, dirty victim ignored.
        issue(1, 32'h0000_1008, 1'b1, 32'hAAAA_5555, 4'b0011, 1'b1, 32'h0000_2000,
              {$urandom, $urandom, $urandom, $urandom});
        wait_idle();

        // Reset while waiting for read beat 1.
        gnt_dly_min = 0; gnt_dly_max = 0; rv_dly_min = 6; rv_dly_max = 6;
        base_gnts = rd_gnts[0];
        issue(0, 32'h0000_4000, 1'b0, '0, '0, 1'b0, '0, '0);
        n = 0;
        while (rd_gnts[0] - base_gnts < 2 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 200) fail_event("reset_setup_timeout");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        for (int g = 0; g < 2; g++) begin
            exp_mem[g].delete();
            exp_done[g].delete();
        end
        @(posedge clk); #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        gnt_dly_max = 2; rv_dly_min = 0; rv_dly_max = 2;
        issue(0, 32'h0000_400C, 1'b0, '0, '0, 1'b1, 32'h0000_5000,
              {$urandom, $urandom, $urandom, $urandom});
        wait_idle();

        // Randomized misses over a small address range so lines get reused.
        gnt_dly_max = 3; rv_dly_max = 3;
        for (int k = 0; k < 40; k++) begin
            int g;
            g = int'($urandom_range(1, 0));
            issue(g, AW'($urandom_range(32'h0FFF, 0)), 1'($urandom), $urandom, BB'($urandom),
                  1'($urandom), AW'($urandom_range(32'h0FFF, 0)),
                  {$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(3, 0) == 0) wait_idle();
        end
        wait_idle();
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
